hv_efuse_loader: RTL and testbench
==================================

# hv_efuse_loader

HV-side eFuse load responder: the slave end of the `efuse_load_req` / `efuse_load_done` handshake driven by the HV control FSM.
- On request it sequences word-by-word reads of the eFuse macro with programmable setup and strobe widths.
- It writes each word into the register file, checks the image, publishes `o_efuse_vld`, and returns a single-cycle done pulse.
- It sits between `hv_ctrl_unit`, the eFuse hard macro and the HV register bank.

## Interface
Parameters:
- EFUSE_WORD_NUM, 8, words read per load (≥2); the last word is the CRC word when CRC is enabled
- EFUSE_DW, 8, eFuse word width (CRC-8 requires 8)
- EFUSE_AW, 3, address width, ≥ clog2(EFUSE_WORD_NUM)
- RD_SETUP_CYC, 2, cycles with address and CSB valid before the strobe (≥1)
- RD_PULSE_CYC, 4, read strobe high width in cycles (≥1)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset: i_rst_n, asynchronous, active-low; clock i_clk
- i_efuse_load_req  in  1  level request; held high until done is sampled
- o_efuse_load_done  out  1  one-cycle completion pulse
- o_efuse_vld  out  1  image-valid flag; valid no later than the done cycle
- o_efuse_busy  out  1  high while a load is in progress (any state other than IDLE)
- o_efuse_csb  out  1  macro chip select, active-low
- o_efuse_addr  out  EFUSE_AW  macro word address
- o_efuse_rd_strb  out  1  macro read strobe
- i_efuse_rdata  in  EFUSE_DW  macro read data; stable from strobe fall until the next address change
- o_efuse_wr_en  out  1  one-cycle register write pulse
- o_efuse_wr_addr  out  EFUSE_AW  register word index
- o_efuse_wr_data  out  EFUSE_DW  register write data

## Operation
- All outputs are registered. Reset values: csb=1; every other output 0, including vld and done.
- FSM states: IDLE, SETUP, STRB, CAPT, CHK, DONE.
- **IDLE**
  - req=1 → SETUP with addr=0, csb=0, counter cleared, CRC accumulator = 0x00, nonblank flag = 0.
  - vld holds its value and is not cleared at load start.
- **SETUP**: csb=0, addr held for RD_SETUP_CYC cycles → STRB.
- **STRB**: rd_strb=1 for RD_PULSE_CYC cycles → CAPT.
- **CAPT** (1 cycle): rd_strb=0. At the closing edge:
  - wr_en<=1, wr_addr<=addr, wr_data<=i_efuse_rdata.
  - The word is folded into the CRC accumulator and the nonblank flag.
  - If addr==EFUSE_WORD_NUM-1 → CHK, else addr+1 → SETUP.
- **CHK** (1 cycle): csb=1. At the closing edge vld<=result, done<=1 → DONE.
- **DONE** (1 cycle): done=1, req ignored; then → IDLE.
- wr_en is high for exactly one cycle per word; exactly EFUSE_WORD_NUM writes occur per completed load.
- Abort: req low in SETUP, STRB or CAPT → IDLE next edge.
  - csb=1, rd_strb=0, no done pulse, vld unchanged.
  - A write already issued stays issued.
- Nonblank flag = OR of all words read in the load.
- Address counter never wraps within a load; the last address is EFUSE_WORD_NUM-1.

## Timing
- req sampled high at edge E0 → SETUP begins at E0 and csb falls at E0.
- Per-word cost: W = RD_SETUP_CYC + RD_PULSE_CYC + 1 cycles (default 7).
- Word n write pulse is high from edge E0+(n+1)·W.
- done=1 from edge E0+EFUSE_WORD_NUM·W+1 for exactly one cycle; default 57.
- vld is updated on the same edge as done rises.
- Back-to-back: req still high in the IDLE cycle after DONE starts a new load.

## Configuration
- Macro: HV_EFUSE_CRC_CHK_EN.
- Defined:
  - Words 0..EFUSE_WORD_NUM-2 are data; word EFUSE_WORD_NUM-1 is the stored CRC.
  - CRC-8: polynomial 0x07, init 0x00, MSB-first, no reflection or xorout, computed over the data words.
  - vld = (computed CRC == last word) & nonblank.
  - The CRC word is still written to the register file.
- Undefined:
  - No CRC logic; all words are data.
  - vld = nonblank.

## Test plan
- Defaults, macro defined; data words 0..5=0x00, word6=0x01, word7=0x07; req at E0
  - → 8 writes at E0+7·(n+1) with correct addr/data;
  - → done at E0+57 for exactly 1 cycle; vld=1 in the same cycle; busy low afterward.
- Same image with word7=0x01 → vld=0 at done.
- All-zero fuse → vld=0, with the macro defined and undefined.
- Strobe timing: per word, csb low for 2 cycles before rd_strb, rd_strb high exactly 4 cycles, csb=1 in CHK and DONE.
- Abort: req dropped during word3 STRB
  - → IDLE next edge; csb=1; no done; vld keeps its prior value; only words 0-2 written.
- Reset asserted mid-load (word5)
  - → all outputs at reset values immediately (csb=1, vld=0);
  - → a fresh req after reset release completes normally in 57 cycles.

Source files
------------

// File: rtl/hv_efuse_loader_if.sv
// eFuse loader bundle: load handshake, eFuse macro read port and register-file write port.
// Latency: wires only.
// Backpressure: none; the load request is a level held by the requester until done.
interface hv_efuse_loader_if #(
    parameter int AW = 3,
    parameter int DW = 8
) ();
    logic          i_efuse_load_req;
    logic          o_efuse_load_done;
    logic          o_efuse_vld;
    logic          o_efuse_busy;
    logic          o_efuse_csb;
    logic [AW-1:0] o_efuse_addr;
    logic          o_efuse_rd_strb;
    logic [DW-1:0] i_efuse_rdata;
    logic          o_efuse_wr_en;
    logic [AW-1:0] o_efuse_wr_addr;
    logic [DW-1:0] o_efuse_wr_data;

    modport slave (
        input  i_efuse_load_req, i_efuse_rdata,
        output o_efuse_load_done, o_efuse_vld, o_efuse_busy, o_efuse_csb,
               o_efuse_addr, o_efuse_rd_strb, o_efuse_wr_en, o_efuse_wr_addr,
               o_efuse_wr_data
    );

    modport master (
        output i_efuse_load_req, i_efuse_rdata,
        input  o_efuse_load_done, o_efuse_vld, o_efuse_busy, o_efuse_csb,
               o_efuse_addr, o_efuse_rd_strb, o_efuse_wr_en, o_efuse_wr_addr,
               o_efuse_wr_data
    );
endinterface

// File: rtl/hv_efuse_loader.sv
// HV eFuse load responder: reads the fuse image word by word into the register bank; HV_EFUSE_CRC_CHK_EN adds CRC-8 image check.
// Latency: EFUSE_WORD_NUM*(RD_SETUP_CYC+RD_PULSE_CYC+1)+1 cycles from req sampled to done.
// Backpressure: none; dropping req before CHK aborts the load with no done pulse.
module hv_efuse_loader #(
    parameter int EFUSE_WORD_NUM = 8,
    parameter int EFUSE_DW       = 8,
    parameter int EFUSE_AW       = 3,
    parameter int RD_SETUP_CYC   = 2,
    parameter int RD_PULSE_CYC   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    hv_efuse_loader_if.slave efuse
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_STRB  = 3'd2;
    localparam logic [2:0] ST_CAPT  = 3'd3;
    localparam logic [2:0] ST_CHK   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam int CMAX = (RD_SETUP_CYC > RD_PULSE_CYC) ? RD_SETUP_CYC : RD_PULSE_CYC;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0]       SETUP_LAST = CW'(RD_SETUP_CYC - 1);
    localparam logic [CW-1:0]       PULSE_LAST = CW'(RD_PULSE_CYC - 1);
    localparam logic [EFUSE_AW-1:0] LAST_ADDR  = EFUSE_AW'(EFUSE_WORD_NUM - 1);

    logic [2:0]          state_q;
    logic [CW-1:0]       cnt_q;
    logic [EFUSE_AW-1:0] addr_q;
    logic                csb_q, strb_q, busy_q, done_q, vld_q, nonblank_q;
    logic                wr_en_q;
    logic [EFUSE_AW-1:0] wr_addr_q;
    logic [EFUSE_DW-1:0] wr_data_q;
    logic                abort;
    logic                result;

`ifdef HV_EFUSE_CRC_CHK_EN
    localparam logic [EFUSE_DW-1:0] CRC_POLY = EFUSE_DW'(8'h07);

    logic [EFUSE_DW-1:0] crc_q;
    logic                crc_ok_q;

    // CRC-8 over one word, MSB first, no reflection.
    function automatic logic [EFUSE_DW-1:0] crc_step(input logic [EFUSE_DW-1:0] crc,
                                                      input logic [EFUSE_DW-1:0] dat);
        logic [EFUSE_DW-1:0] r;
        r = crc ^ dat;
        for (int i = 0; i < EFUSE_DW; i++) begin
            r = r[EFUSE_DW-1] ? ({r[EFUSE_DW-2:0], 1'b0} ^ CRC_POLY) : {r[EFUSE_DW-2:0], 1'b0};
        end
        return r;
    endfunction

    assign result = crc_ok_q & nonblank_q;
`else
    assign result = nonblank_q;
`endif

    assign abort = !efuse.i_efuse_load_req &&
                   (state_q == ST_SETUP || state_q == ST_STRB || state_q == ST_CAPT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            csb_q      <= 1'b1;
            strb_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            vld_q      <= 1'b0;
            nonblank_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
`ifdef HV_EFUSE_CRC_CHK_EN
            crc_q      <= '0;
            crc_ok_q   <= 1'b0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            if (abort) begin
                // Writes already issued stay issued; vld keeps the last completed result.
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                csb_q   <= 1'b1;
                strb_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (efuse.i_efuse_load_req) begin
                            state_q    <= ST_SETUP;
                            cnt_q      <= '0;
                            addr_q     <= '0;
                            csb_q      <= 1'b0;
                            busy_q     <= 1'b1;
                            nonblank_q <= 1'b0;
`ifdef HV_EFUSE_CRC_CHK_EN
                            crc_q      <= '0;
`endif
                        end
                    end
                    ST_SETUP: begin
                        if (cnt_q == SETUP_LAST) begin
                            state_q <= ST_STRB;
                            cnt_q   <= '0;
                            strb_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    ST_STRB: begin
                        if (cnt_q == PULSE_LAST) begin
                            state_q <= ST_CAPT;
                            cnt_q   <= '0;
                            strb_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    ST_CAPT: begin
                        wr_en_q    <= 1'b1;
                        wr_addr_q  <= addr_q;
                        wr_data_q  <= efuse.i_efuse_rdata;
                        nonblank_q <= nonblank_q | (|efuse.i_efuse_rdata);
`ifdef HV_EFUSE_CRC_CHK_EN
                        if (addr_q == LAST_ADDR) begin
                            crc_ok_q <= (crc_q == efuse.i_efuse_rdata);
                        end else begin
                            crc_q <= crc_step(crc_q, efuse.i_efuse_rdata);
                        end
`endif
                        if (addr_q == LAST_ADDR) begin
                            state_q <= ST_CHK;
                            csb_q   <= 1'b1;
                        end else begin
                            state_q <= ST_SETUP;
                            addr_q  <= addr_q + EFUSE_AW'(1);
                        end
                    end
                    ST_CHK: begin
                        vld_q   <= result;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        csb_q   <= 1'b1;
                        strb_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign efuse.o_efuse_load_done = done_q;
    assign efuse.o_efuse_vld       = vld_q;
    assign efuse.o_efuse_busy      = busy_q;
    assign efuse.o_efuse_csb       = csb_q;
    assign efuse.o_efuse_addr      = addr_q;
    assign efuse.o_efuse_rd_strb   = strb_q;
    assign efuse.o_efuse_wr_en     = wr_en_q;
    assign efuse.o_efuse_wr_addr   = wr_addr_q;
    assign efuse.o_efuse_wr_data   = wr_data_q;
endmodule

// File: tb/tb_hv_efuse_loader.sv
// Directed bench for hv_efuse_loader: full loads, CRC pass/fail images, abort and mid-load reset.
module tb_hv_efuse_loader;
`ifdef HV_EFUSE_CRC_CHK_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif
    localparam logic [63:0] IMG_A    = 64'h0701_0000_0000_0000;
    localparam logic [63:0] IMG_ABAD = 64'h0101_0000_0000_0000;
    localparam logic [63:0] IMG_D    = 64'h123E_1302_1D0A_0B03;
    localparam logic [63:0] IMG_ZERO = 64'h0;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_bad = 0;
    int   e0 = 0;
    bit   log_en = 1'b0;

    logic [7:0] img [8];
    logic       strb_d = 1'b0;
    logic [2:0] addr_d = 3'd0;

    logic       lg_csb  [64];
    logic       lg_strb [64];
    logic       lg_busy [64];
    logic       lg_done [64];
    logic [2:0] lg_addr [64];
    int         wq_idx  [$];
    logic [2:0] wq_addr [$];
    logic [7:0] wq_data [$];

    hv_efuse_loader_if #(.AW(3), .DW(8)) bus ();

    hv_efuse_loader #(
        .EFUSE_WORD_NUM(8), .EFUSE_DW(8), .EFUSE_AW(3),
        .RD_SETUP_CYC(2), .RD_PULSE_CYC(4)
    ) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .efuse   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Fuse macro: data appears after the strobe falls and is garbage after an address change.
    always @(posedge clk) begin
        #1;
        if (strb_d && !bus.o_efuse_rd_strb)
            bus.i_efuse_rdata = img[bus.o_efuse_addr];
        else if (addr_d != bus.o_efuse_addr)
            bus.i_efuse_rdata = 8'hEE;
        strb_d = bus.o_efuse_rd_strb;
        addr_d = bus.o_efuse_addr;
    end

    always @(negedge clk) begin : mon
        int k;
        if (log_en) begin
            k = cyc - e0;
            if (k >= 0 && k < 64) begin
                lg_csb[k]  = bus.o_efuse_csb;
                lg_strb[k] = bus.o_efuse_rd_strb;
                lg_busy[k] = bus.o_efuse_busy;
                lg_done[k] = bus.o_efuse_load_done;
                lg_addr[k] = bus.o_efuse_addr;
            end
            if (bus.o_efuse_wr_en) begin
                wq_idx.push_back(k);
                wq_addr.push_back(bus.o_efuse_wr_addr);
                wq_data.push_back(bus.o_efuse_wr_data);
            end
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_img(input logic [63:0] v);
        for (int i = 0; i < 8; i++) img[i] = v[8*i +: 8];
    endtask

    task automatic start_load(input logic [63:0] v);
        set_img(v);
        @(negedge clk);
        wq_idx.delete();
        wq_addr.delete();
        wq_data.delete();
        e0 = cyc + 1;
        log_en = 1'b1;
        bus.i_efuse_load_req = 1'b1;
    endtask

    task automatic run_full(input string tag, input logic [63:0] v, input logic exp_vld);
        int         t;
        int         nw;
        logic [6:0] sp;
        logic [6:0] cp;
        start_load(v);
        t = 0;
        while (bus.o_efuse_load_done !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk_eq({tag, "_done_seen"}, bus.o_efuse_load_done, 1);
        chk_eq({tag, "_done_cyc"}, cyc - e0, 57);
        chk_eq({tag, "_vld"}, bus.o_efuse_vld, exp_vld);
        bus.i_efuse_load_req = 1'b0;
        repeat (4) @(negedge clk);
        log_en = 1'b0;
        chk_eq({tag, "_done_width"}, lg_done[58], 0);
        chk_eq({tag, "_busy_after"}, lg_busy[58], 0);
        chk_eq({tag, "_csb_chk_done"}, {lg_csb[56], lg_csb[57]}, 2'b11);
        for (int w = 0; w < 8; w++) begin
            for (int j = 0; j < 7; j++) begin
                sp[6-j] = lg_strb[7*w + j];
                cp[6-j] = lg_csb[7*w + j];
            end
            chk_eq($sformatf("%s_strb_w%0d", tag, w), sp, 7'b0011110);
            chk_eq($sformatf("%s_csb_w%0d", tag, w), cp, 7'b0000000);
            chk_eq($sformatf("%s_addr_w%0d", tag, w), {lg_addr[7*w], lg_addr[7*w+6]}, {w[2:0], w[2:0]});
        end
        nw = wq_idx.size();
        chk_eq({tag, "_nwrites"}, nw, 8);
        for (int n = 0; n < nw && n < 8; n++) begin
            chk_eq($sformatf("%s_wr_cyc%0d", tag, n), wq_idx[n], 7*(n+1));
            chk_eq($sformatf("%s_wr_addr%0d", tag, n), wq_addr[n], n);
            chk_eq($sformatf("%s_wr_data%0d", tag, n), wq_data[n], v[8*n +: 8]);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_eq({tag, "_csb"}, bus.o_efuse_csb, 1);
        chk_eq({tag, "_vld"}, bus.o_efuse_vld, 0);
        chk_eq({tag, "_done"}, bus.o_efuse_load_done, 0);
        chk_eq({tag, "_busy"}, bus.o_efuse_busy, 0);
        chk_eq({tag, "_strb"}, bus.o_efuse_rd_strb, 0);
        chk_eq({tag, "_wr_en"}, bus.o_efuse_wr_en, 0);
        chk_eq({tag, "_addrs"}, {bus.o_efuse_addr, bus.o_efuse_wr_addr}, 0);
        chk_eq({tag, "_wr_data"}, bus.o_efuse_wr_data, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int dn;
        rst_n = 1'b0;
        bus.i_efuse_load_req = 1'b0;
        bus.i_efuse_rdata = 8'h00;
        set_img(IMG_ZERO);
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_full("imgA", IMG_A, 1'b1);
        run_full("imgAbad", IMG_ABAD, CRC_ON ? 1'b0 : 1'b1);
        run_full("imgD", IMG_D, 1'b1);

        // Abort during word 3 strobe; vld must keep the value from imgD.
        start_load(IMG_D);
        repeat (25) @(negedge clk);
        chk_eq("abort_in_strb", {bus.o_efuse_rd_strb, bus.o_efuse_addr}, {1'b1, 3'd3});
        bus.i_efuse_load_req = 1'b0;
        @(negedge clk);
        chk_eq("abort_idle", {bus.o_efuse_csb, bus.o_efuse_rd_strb, bus.o_efuse_busy}, 3'b100);
        dn = 0;
        repeat (70) begin
            @(negedge clk);
            if (bus.o_efuse_load_done) dn++;
        end
        log_en = 1'b0;
        chk_eq("abort_no_done", dn, 0);
        chk_eq("abort_nwrites", wq_idx.size(), 3);
        chk_eq("abort_vld_kept", bus.o_efuse_vld, 1);

        run_full("imgZero", IMG_ZERO, 1'b0);
        run_full("imgA2", IMG_A, 1'b1);

        // Reset asserted mid-load (word 5) after a valid image was published.
        start_load(IMG_A);
        repeat (37) @(negedge clk);
        chk_eq("mid_addr", bus.o_efuse_addr, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        bus.i_efuse_load_req = 1'b0;
        log_en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_full("postrst", IMG_A, 1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
